// File: rtl/b07_point_loader.sv
`default_nettype none
// ============================================================================
// Module   : b07_point_loader
// Purpose  : Loads a DEPTH x 8-bit point table from a valid/ready byte stream,
//            then hands the full table to a downstream evaluator with a
//            registered start/busy handshake. The table is frozen while the
//            evaluator runs. A start that is never acknowledged times out,
//            raises a sticky error and drops the partial pass.
// Ports    : clock       - single rising-edge clock
//            reset       - synchronous, active-low reset
//            in_valid    - upstream byte present
//            in_data     - upstream byte
//            in_ready    - loader accepts a byte this cycle
//            rd_addr     - evaluator read address
//            rd_data     - table[rd_addr], combinational
//            busy        - evaluator is running a pass
//            start       - registered request to begin a pass
//            table_full  - every entry written for the current pass
//            pass_cnt    - passes handed off, wraps 255->0
//            timeout_err - sticky: a start handoff timed out
// Revision : 1.0 - initial release
// ============================================================================
module b07_point_loader #(
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 64,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          busy,
  output logic          start,
  output logic          table_full,
  output logic [7:0]    pass_cnt,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  // The counter holds the number of busy==0 cycles already spent in START,
  // so the timeout fires on the edge that closes the START_TIMEOUT-th cycle.
  localparam logic [6:0]    TMO_LAST = 7'(START_TIMEOUT - 1);

  state_t          state_q,       state_d;
  logic [AW-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [7:0]      tbl_q [DEPTH];
  logic [7:0]      tbl_d [DEPTH];
  logic            start_q,       start_d;
  logic            table_full_q,  table_full_d;
  logic [7:0]      pass_cnt_q,    pass_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic [6:0]      tmo_cnt_q,     tmo_cnt_d;
  logic            xfer;

  // in_ready is forced low while reset is applied so no byte is ever
  // reported as consumed in a cycle that the reset will discard.
  assign in_ready    = (state_q == S_FILL) && reset;
  assign xfer        = in_valid && in_ready;

  // Read straight from the registers: a same-cycle write shows up next cycle.
  assign rd_data     = tbl_q[rd_addr];
  assign start       = start_q;
  assign table_full  = table_full_q;
  assign pass_cnt    = pass_cnt_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    tbl_d         = tbl_q;
    start_d       = 1'b0;
    table_full_d  = table_full_q;
    pass_cnt_d    = pass_cnt_q;
    timeout_err_d = timeout_err_q;
    tmo_cnt_d     = tmo_cnt_q;

    case (state_q)
      S_FILL: begin
        // busy is deliberately ignored here.
        if (xfer) begin
          tbl_d[wr_ptr_q] = in_data;
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d     = '0;
            table_full_d = 1'b1;
            state_d      = S_START;
            start_d      = 1'b1;
            tmo_cnt_d    = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end

      S_START: begin
        if (busy) begin
          state_d    = S_DRAIN;
          pass_cnt_d = pass_cnt_q + 8'd1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Abandon this pass: the loaded data is treated as stale.
          timeout_err_d = 1'b1;
          table_full_d  = 1'b0;
          wr_ptr_d      = '0;
          state_d       = S_FILL;
        end else begin
          start_d   = 1'b1;
          tmo_cnt_d = (tmo_cnt_q == 7'h7F) ? tmo_cnt_q : tmo_cnt_q + 7'd1;
        end
      end

      S_DRAIN: begin
        if (!busy) begin
          table_full_d = 1'b0;
          state_d      = S_FILL;
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_FILL;
      wr_ptr_q      <= '0;
      tbl_q         <= '{default: 8'h00};
      start_q       <= 1'b0;
      table_full_q  <= 1'b0;
      pass_cnt_q    <= 8'h00;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      tbl_q         <= tbl_d;
      start_q       <= start_d;
      table_full_q  <= table_full_d;
      pass_cnt_q    <= pass_cnt_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

endmodule
`default_nettype wire
